// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: widths, conversion FSM
// states and the active-low seven-segment encoding.
package score_display_pkg;

  localparam int SCORE_W = 6;
  localparam int BCD_W   = 8;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    if (digit <= 4'd9) begin
      return SEG_LUT[digit];
    end
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble: converts a 6-bit binary value to two BCD digits,
// one shift per cycle, and flags the commit cycle to the parent.
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [SCORE_W-1:0] i_bin,
  output logic               o_commit,
  output logic [BCD_W-1:0]   o_bcd,
  output logic [SCORE_W-1:0] o_value
);

  conv_state_t        r_state;
  conv_state_t        w_state_next;
  logic [SCORE_W-1:0] r_bin;
  logic [SCORE_W-1:0] r_value;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic               w_capture;
  logic               w_clear;
  logic               w_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = LOAD;
      LOAD:    w_state_next = SHIFT;
      SHIFT:   if (r_cnt == CNT_W'(SCORE_W - 1)) w_state_next = COMMIT;
      COMMIT:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_capture = (r_state == IDLE) && i_start;
    w_clear   = (r_state == LOAD);
    w_shift   = (r_state == SHIFT);
    o_commit  = (r_state == COMMIT);
  end

  // Add-3 correction on every nibble that would overflow past 9 after shifting
  genvar gi;
  generate
    for (gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
      assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                    r_bcd[gi*4 +: 4] + 4'd3 : r_bcd[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin   <= '0;
      r_value <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_capture) begin
        r_bin   <= i_bin;
        r_value <= i_bin;
      end
      if (w_clear) begin
        r_bcd <= '0;
        r_cnt <= '0;
      end
      if (w_shift) begin
        r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
        r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_bcd   = r_bcd;
  assign o_value = r_value;

endmodule

// File: rtl/score_display.sv
// Score display top: retriggers BCD conversion whenever the score moves and
// scans the two digits across a 4-digit common-anode display.
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score_count,
  output logic [6:0]         seg,
  output logic [3:0]         an,
  output logic               dp,
  output logic               conv_done
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

  logic [SCORE_W-1:0] r_last_val;
  logic [3:0]         r_tens;
  logic [3:0]         r_ones;
  logic [RW-1:0]      r_refresh;
  logic [1:0]         r_idx;
  logic [6:0]         r_seg;
  logic [3:0]         r_an;
  logic               r_conv_done;

  logic               w_start;
  logic               w_commit;
  logic [BCD_W-1:0]   w_bcd;
  logic [SCORE_W-1:0] w_value;
  logic               w_wrap;
  logic [RW-1:0]      w_refresh_next;
  logic [1:0]         w_idx_next;
  logic [3:0]         w_tens_next;
  logic [3:0]         w_ones_next;
  logic [6:0]         w_seg_next;
  logic [3:0]         w_an_next;

  assign w_start = (score_count != r_last_val);

  bin2bcd_seq u_conv (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_start),
    .i_bin    (score_count),
    .o_commit (w_commit),
    .o_bcd    (w_bcd),
    .o_value  (w_value)
  );

  // Outputs are built from next-state values so seg/an/digits move together
  always_comb begin
    w_wrap         = (r_refresh == REFRESH_MAX);
    w_refresh_next = w_wrap ? '0 : r_refresh + 1'b1;
    w_idx_next     = w_wrap ? r_idx + 2'd1 : r_idx;
    w_tens_next    = w_commit ? w_bcd[7:4] : r_tens;
    w_ones_next    = w_commit ? w_bcd[3:0] : r_ones;
    w_an_next      = ~(4'b0001 << w_idx_next);
    case (w_idx_next)
      2'd0:    w_seg_next = seg_encode(w_ones_next);
      2'd1:    w_seg_next = (w_tens_next == 4'd0) ? SEG_BLANK : seg_encode(w_tens_next);
      default: w_seg_next = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_val  <= '0;
      r_tens      <= '0;
      r_ones      <= '0;
      r_refresh   <= '0;
      r_idx       <= '0;
      r_seg       <= 7'h40;
      r_an        <= 4'b1110;
      r_conv_done <= 1'b0;
    end else begin
      r_refresh   <= w_refresh_next;
      r_idx       <= w_idx_next;
      r_tens      <= w_tens_next;
      r_ones      <= w_ones_next;
      r_seg       <= w_seg_next;
      r_an        <= w_an_next;
      r_conv_done <= w_commit;
      if (w_commit) begin
        r_last_val <= w_value;
      end
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign dp        = 1'b1;
  assign conv_done = r_conv_done;

endmodule

// File: tb/tb_score_display.sv
// Randomized and directed bench for score_display against a cycle-level
// behavioural model of conversion latency, digit values and scan slots.
module tb_score_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] score_count = 6'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       conv_done;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int       m_timer;
  int       m_edges;
  int       m_tens;
  int       m_ones;
  int       m_commits;
  bit       m_done;
  bit [5:0] m_last;
  bit [5:0] m_cap;
  logic [6:0] ref_lut [0:9];

  score_display #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .score_count (score_count),
    .seg         (seg),
    .an          (an),
    .dp          (dp),
    .conv_done   (conv_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg();
    int slot;
    slot = (m_edges / DIV) % 4;
    if (slot == 0) return ref_lut[m_ones];
    if (slot == 1) return (m_tens == 0) ? 7'h7F : ref_lut[m_tens];
    return 7'h7F;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] a;
    a = 4'b1111;
    a[(m_edges / DIV) % 4] = 1'b0;
    return a;
  endfunction

  task automatic model_reset();
    m_timer = 0;
    m_edges = 0;
    m_tens  = 0;
    m_ones  = 0;
    m_done  = 0;
    m_last  = 6'd0;
    m_cap   = 6'd0;
  endtask

  // Input sampled while idle is converted; commit lands 9 edges later
  task automatic model_step();
    m_done = 0;
    m_edges++;
    if (m_timer == 0) begin
      if (score_count != m_last) begin
        m_cap   = score_count;
        m_timer = 1;
      end
    end else begin
      m_timer++;
      if (m_timer == 9) begin
        m_last  = m_cap;
        m_tens  = m_cap / 10;
        m_ones  = m_cap % 10;
        m_done  = 1;
        m_timer = 0;
        m_commits++;
      end
    end
  endtask

  task automatic compare();
    chk("an", an, exp_an());
    chk("seg", seg, exp_seg());
    chk("dp", dp, 1'b1);
    chk("conv_done", conv_done, m_done);
    chk("tens", dut.r_tens, m_tens);
    chk("ones", dut.r_ones, m_ones);
    if (m_done) $display("commit value %0d -> %0d%0d", m_last, m_tens, m_ones);
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      compare();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    #2;
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'h40);
    chk("rst_dp", dp, 1'b1);
    chk("rst_done", conv_done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int c0;
    ref_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    m_commits = 0;
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();

    // Quiet score of zero: plain scan, no conversions
    tick(2 * 4 * DIV);
    chk("zero_no_commit", m_commits, 0);

    // 0 -> 32, then 7 (leading blank)
    score_count = 6'd32;
    tick(3 * 4 * DIV);
    score_count = 6'd7;
    tick(3 * 4 * DIV);

    // 5 then 63 mid-conversion: two commits
    score_count = 6'd5;
    tick(2 * 4 * DIV);
    c0 = m_commits;
    score_count = 6'd0;
    tick(4);
    score_count = 6'd63;
    tick(3 * 4 * DIV);
    score_count = 6'd5;
    tick(1);
    c0 = m_commits;
    tick(3);
    score_count = 6'd63;
    tick(30);
    chk("two_commits", m_commits - c0, 2);

    // Sweep every value
    for (int v = 0; v < 64; v++) begin
      score_count = 6'(v);
      tick(12);
    end

    // Reset during the conversion of 0 -> 19
    apply_reset();
    tick(3);
    score_count = 6'd19;
    tick(4);
    apply_reset();
    tick(2 * 4 * DIV);
    chk("post_reset_tens", dut.r_tens, 4'd1);
    chk("post_reset_ones", dut.r_ones, 4'd9);

    // Random changes at random times, including mid-conversion
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) score_count = 6'($urandom_range(0, 63));
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
